halt_dump_unit: RTL

- Sits beside the CPU core and data memory in top, downstream of the core's fetch/decode instruction stream.
- Detects the two HALT encodings, then counts a fixed pipeline-drain interval.
- Reads a configurable window of data memory through a dedicated synchronous read port and streams each word out on a valid/ready interface.
- Gives the bench and on-chip debug a deterministic halted/done indication plus a memory result dump, without hierarchical peeking.

---
 rtl/halt_dump_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/halt_dump_unit.sv
// halt_dump_unit
//   Watches the core's decode-stage instruction stream for a HALT, waits a
//   fixed number of cycles for the pipeline to drain, then reads a window of
//   data memory through a private synchronous read port and streams each word
//   out on a valid/ready interface. halted/done give the bench and on-chip
//   debug a deterministic end-of-program indication.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   instr        in   INSTR_W  instruction in decode
//   instr_valid  in   instr is a real instruction (not a bubble)
//   mem_rd_en    out  data memory read strobe
//   mem_rd_addr  out  ADDR_W   data memory read address
//   mem_rd_data  in   DATA_W   read data, valid the cycle after mem_rd_en
//   dump_valid   out  dump_data/dump_addr hold a valid word
//   dump_ready   in   consumer accepts the word
//   dump_data    out  DATA_W   dumped word
//   dump_addr    out  ADDR_W   address of the dumped word
//   halted       out  HALT seen, sticky until reset
//   done         out  drain and dump complete, sticky until reset

module halt_dump_unit #(
    parameter int INSTR_W      = 16,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 8,
    parameter int DRAIN_CYCLES = 10,
    parameter int DUMP_BASE    = 1,
    parameter int DUMP_COUNT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic              instr_valid,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              halted,
    output logic              done
);

    // Drain counter must hold DRAIN_CYCLES itself.
    localparam int CNT_W  = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    // Word counter is one bit wider than the address so a full 2^ADDR_W
    // window can be expressed.
    localparam int SENT_W = ADDR_W + 1;

    localparam logic [INSTR_W-1:0] HALT_A = INSTR_W'(16'hE000);
    localparam logic [INSTR_W-1:0] HALT_B = INSTR_W'(16'hE7FF);
    localparam logic [SENT_W-1:0]  COUNT  = SENT_W'(DUMP_COUNT);
    localparam logic [ADDR_W-1:0]  BASE   = ADDR_W'(DUMP_BASE);
    localparam logic [CNT_W-1:0]   DRAIN  = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_READ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ptr;
    logic [SENT_W-1:0] sent;
    logic [SENT_W-1:0] sent_inc;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              halt_hit;
    logic              handshake;
    logic              last_word;

    // Only the two exact encodings halt; the rest of the 11100xxx... space
    // is ordinary instructions.
    assign halt_hit  = instr_valid && ((instr == HALT_A) || (instr == HALT_B));
    assign handshake = (state == S_HOLD) && dump_ready;
    assign sent_inc  = sent + SENT_W'(1);
    assign last_word = (sent_inc == COUNT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN: begin
                if (halt_hit) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Leaving on counter==1 makes DRAIN last exactly DRAIN_CYCLES.
                if (cnt == CNT_W'(1))
                    state_nxt = (DUMP_COUNT > 0) ? S_READ : S_DONE;
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_HOLD;
            S_HOLD: begin
                if (dump_ready) state_nxt = last_word ? S_DONE : S_READ;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        dump_valid  = 1'b0;
        halted      = 1'b1;
        done        = 1'b0;
        unique case (state)
            S_RUN:  halted = 1'b0;
            S_READ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = ptr;
            end
            // A word is presented for exactly as long as we sit in HOLD, so
            // the handshake edge drops valid on the next cycle.
            S_HOLD: dump_valid = 1'b1;
            S_DONE: done       = 1'b1;
            default: ;
        endcase
    end

    assign dump_data = data_q;
    assign dump_addr = addr_q;

    // ------------------------------------------------------------------
    // Datapath: drain counter, read pointer, word count, output capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            ptr    <= '0;
            sent   <= '0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            if ((state == S_RUN) && halt_hit) begin
                cnt  <= DRAIN;
                ptr  <= BASE;
                sent <= '0;
            end else if (state == S_DRAIN) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Read data arrives one cycle after the strobe, i.e. during WAIT.
            if (state == S_WAIT) begin
                data_q <= mem_rd_data;
                addr_q <= ptr;
            end

            // Pointer wraps naturally modulo 2^ADDR_W.
            if (handshake) begin
                sent <= sent_inc;
                ptr  <= ptr + ADDR_W'(1);
            end
        end
    end

endmodule
